// File: rtl/shifter_pipe_pkg.sv
// Shared shift-kind encodings and instruction field positions for the
// ARM7 operand-2 shifter. Imported by the shifter and its stage module.
package shifter_pipe_pkg;

  // Kind carried down the pipe; values match the instruction sh field.
  typedef enum logic [1:0] {
    SK_LSL = 2'b00,
    SK_LSR = 2'b01,
    SK_ASR = 2'b10,
    SK_ROR = 2'b11
  } shift_kind_e;

  localparam int SH_LSB      = 5;  // imm_value[6:5]  shift type
  localparam int BY_REG_BIT  = 4;  // imm_value[4]    amount from Rs
  localparam int IMM_AMT_LSB = 7;  // imm_value[11:7] immediate amount
  localparam int ROT_LSB     = 8;  // imm_value[11:8] immediate rotate/2

  function automatic shift_kind_e sh_to_kind(input logic [1:0] sh);
    return shift_kind_e'(sh);
  endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One elastic pipeline slot of the operand-2 shifter: applies the log-shift
// layers LAYER_LO..LAYER_HI-1 to the incoming operand, then registers it.
// Ports: clk, rst (async, high), adv (slot load enable), vld_in/vld_out,
// data/carry/kind/amount in and out.
module shifter_stage
  import shifter_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int AW       = 5,
  parameter int LAYER_LO = 0,
  parameter int LAYER_HI = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     adv,
  input  logic                     vld_in,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     c_in,
  input  shift_kind_e              kind_in,
  input  logic [AW-1:0]            amt_in,
  output logic                     vld_out,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     c_out,
  output shift_kind_e              kind_out,
  output logic [AW-1:0]            amt_out
);

  logic signed [DATA_W-1:0] data_mid;
  logic                     c_mid;
  logic                     vld_p;
  logic signed [DATA_W-1:0] data_p;
  logic                     c_p;
  shift_kind_e              kind_p;
  logic [AW-1:0]            amt_p;

  // Shift by s; carry is the last bit shifted out, except ROR where it is the
  // new MSB. Chaining layers keeps the carry of the last active layer.
  function automatic logic [DATA_W:0] shift_layer(
    input logic signed [DATA_W-1:0] d,
    input logic                     c,
    input shift_kind_e              k,
    input int                       s
  );
    logic signed [DATA_W-1:0] r;
    logic                     co;
    r  = d;
    co = c;
    case (k)
      SK_LSL: begin
        r  = d <<< s;
        co = d[DATA_W-s];
      end
      SK_LSR: begin
        r  = d >> s;
        co = d[s-1];
      end
      SK_ASR: begin
        r  = d >>> s;
        co = d[s-1];
      end
      default: begin
        r  = (d >> s) | (d << (DATA_W - s));
        co = r[DATA_W-1];
      end
    endcase
    return {co, r};
  endfunction

  always_comb begin
    data_mid = data_in;
    c_mid    = c_in;
    for (int i = LAYER_LO; i < LAYER_HI; i++) begin
      if (amt_in[i]) begin
        {c_mid, data_mid} = shift_layer(data_mid, c_mid, kind_in, 1 << i);
      end
    end
  end

  // ---- stage register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= 1'b0;
    end else if (adv) begin
      vld_p <= vld_in;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      data_p <= data_mid;
      c_p    <= c_mid;
      kind_p <= kind_in;
      amt_p  <= amt_in;
    end
  end

  assign vld_out  = vld_p;
  assign data_out = data_p;
  assign c_out    = c_p;
  assign kind_out = kind_p;
  assign amt_out  = amt_p;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined ARM7 operand-2 barrel shifter with valid/ready handshake.
// Stage-0 decode resolves kind, amount and every special case (amount 0,
// amount >= N, RRX, immediate rotate, bypass) so the layered stages only
// ever see plain shifts of 0..N-1.
// Ports: in_valid/in_ready request side; instr_bit_25, imm_value, rm, rs,
// cin, use_shifter, direct_data operands; out_valid/out_ready result side;
// operand2, c_out result. rst is asynchronous, active-high.
module shifter_pipe
  import shifter_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              instr_bit_25,
  input  logic [11:0]       imm_value,
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs,
  input  logic              cin,
  input  logic              use_shifter,
  input  logic [DATA_W-1:0] direct_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] operand2,
  output logic              c_out
);

  localparam int AW = $clog2(DATA_W);

  logic signed [DATA_W-1:0] dec_data;
  logic                     dec_c;
  shift_kind_e              dec_kind;
  logic [AW-1:0]            dec_amt;
  logic [31:0]              amt_full;
  logic                     imm_amt_zero;

  logic signed [DATA_W-1:0] data_p [STAGES];
  logic                     c_p    [STAGES];
  shift_kind_e              kind_p [STAGES];
  logic [AW-1:0]            amt_p  [STAGES];
  logic [STAGES-1:0]        vld_p;
  logic [STAGES-1:0]        adv_p;

  assign imm_amt_zero = (imm_value[11:IMM_AMT_LSB] == 5'd0);

  // ---- stage-0 decode ----
  always_comb begin
    dec_data = rm;
    dec_c    = cin;
    dec_kind = SK_ROR;
    dec_amt  = '0;
    amt_full = '0;
    if (!use_shifter) begin
      dec_data = direct_data;
    end else if (instr_bit_25) begin
      dec_data      = '0;
      dec_data[7:0] = imm_value[7:0];
      dec_amt       = AW'({imm_value[11:ROT_LSB], 1'b0});
    end else begin
      dec_kind = sh_to_kind(imm_value[SH_LSB+1:SH_LSB]);
      if (imm_value[BY_REG_BIT]) begin
        amt_full = {24'd0, rs};
      end else if (!imm_amt_zero) begin
        amt_full = {27'd0, imm_value[11:IMM_AMT_LSB]};
      end else if (dec_kind != SK_LSL) begin
        amt_full = 32'(DATA_W);
      end
      dec_amt = amt_full[AW-1:0];
      case (dec_kind)
        SK_LSL, SK_LSR: begin
          if (amt_full >= 32'(DATA_W)) begin
            dec_amt  = '0;
            dec_data = '0;
            if (amt_full == 32'(DATA_W)) begin
              dec_c = (dec_kind == SK_LSL) ? rm[0] : rm[DATA_W-1];
            end else begin
              dec_c = 1'b0;
            end
          end
        end
        SK_ASR: begin
          if (amt_full >= 32'(DATA_W)) begin
            dec_amt  = '0;
            dec_data = {DATA_W{rm[DATA_W-1]}};
            dec_c    = rm[DATA_W-1];
          end
        end
        default: begin
          if (!imm_value[BY_REG_BIT] && imm_amt_zero) begin
            dec_amt  = '0;
            dec_data = {cin, rm[DATA_W-1:1]};
            dec_c    = rm[0];
          end else if (amt_full != 32'd0 && dec_amt == '0) begin
            dec_c = rm[DATA_W-1];
          end
        end
      endcase
    end
  end

  // Bubble-collapsing advance chain, from the output back to the input.
  always_comb begin
    adv_p             = '0;
    adv_p[STAGES-1]   = ~vld_p[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_p[k] = ~vld_p[k] | adv_p[k+1];
    end
  end

  assign in_ready = adv_p[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                     s_vld;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_c;
    shift_kind_e              s_kind;
    logic [AW-1:0]            s_amt;

    if (k == 0) begin : g_first
      assign s_vld  = in_valid;
      assign s_data = dec_data;
      assign s_c    = dec_c;
      assign s_kind = dec_kind;
      assign s_amt  = dec_amt;
    end else begin : g_next
      assign s_vld  = vld_p[k-1];
      assign s_data = data_p[k-1];
      assign s_c    = c_p[k-1];
      assign s_kind = kind_p[k-1];
      assign s_amt  = amt_p[k-1];
    end

    // ---- stage k boundary ----
    shifter_stage #(
      .DATA_W  (DATA_W),
      .AW      (AW),
      .LAYER_LO(k * AW / STAGES),
      .LAYER_HI((k + 1) * AW / STAGES)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv_p[k]),
      .vld_in  (s_vld),
      .data_in (s_data),
      .c_in    (s_c),
      .kind_in (s_kind),
      .amt_in  (s_amt),
      .vld_out (vld_p[k]),
      .data_out(data_p[k]),
      .c_out   (c_p[k]),
      .kind_out(kind_p[k]),
      .amt_out (amt_p[k])
    );
  end

  // Result reads as zero whenever no valid op is presented.
  assign out_valid = vld_p[STAGES-1];
  assign operand2  = vld_p[STAGES-1] ? data_p[STAGES-1] : '0;
  assign c_out     = vld_p[STAGES-1] & c_p[STAGES-1];

endmodule
